// File: rtl/mem_stage_controller.sv
// Memory-stage access sequencer: issues one req/ack transaction per load or store in M,
// stalls the front of the pipeline while it is outstanding and times out a silent memory.
module mem_stage_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic                  AddrModeM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_byte,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  StallM,
    output logic                  BubbleW,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  ReadValidM,
    output logic                  ErrorM
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_req;
    logic                  r_we;
    logic                  r_byte;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;
    logic                  r_error;
    logic                  w_cnt_sat;
    logic                  w_stall;

    assign w_cnt_sat = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_byte   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (MemReqM) begin
                        r_addr  <= ALUResultM;
                        r_wdata <= WriteDataM;
                        r_we    <= MemWriteM;
                        r_byte  <= AddrModeM;
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= StBusy;
                    end
                end
                StBusy: begin
                    if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                    // A late ack that coincides with the timeout still completes normally.
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_rdata  <= mem_rdata;
                            r_rvalid <= 1'b1;
                        end
                        r_req   <= 1'b0;
                        r_state <= StDone;
                    end else if (r_cnt == CNT_LAST) begin
                        r_error <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= '0;
                        end
                        r_req   <= 1'b0;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    // MemReqM still refers to the finished instruction here; do not restart.
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_stall = ((r_state == StIdle) & MemReqM) | (r_state == StBusy);

    assign mem_req    = r_req;
    assign mem_we     = r_we;
    assign mem_byte   = r_byte;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign StallM     = w_stall;
    assign BubbleW    = w_stall;
    assign ReadDataM  = r_rdata;
    assign ReadValidM = r_rvalid;
    assign ErrorM     = r_error;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Bench for mem_stage_controller: a transaction-level model checked every cycle, plus
// directed scenarios with literal expectations on cycle counts and captured data.
module tb_mem_stage_controller;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          MemReqM = 1'b0;
    logic          MemWriteM = 1'b0;
    logic          AddrModeM = 1'b0;
    logic [DW-1:0] ALUResultM = '0;
    logic [DW-1:0] WriteDataM = '0;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_req, mem_we, mem_byte;
    logic [DW-1:0] mem_addr, mem_wdata, ReadDataM;
    logic          StallM, BubbleW, ReadValidM, ErrorM;

    mem_stage_controller #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemReqM   (MemReqM),
        .MemWriteM (MemWriteM),
        .AddrModeM (AddrModeM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .StallM    (StallM),
        .BubbleW   (BubbleW),
        .ReadDataM (ReadDataM),
        .ReadValidM(ReadValidM),
        .ErrorM    (ErrorM)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory responder: ack in the ack_lat-th cycle of a request (0 = never), or always.
    int   ack_lat   = 0;
    logic force_ack = 1'b0;
    int   req_age;
    always @(posedge clk or posedge rst) begin
        if (rst) req_age <= 0;
        else     req_age <= mem_req ? req_age + 1 : 0;
    end
    assign mem_ack = force_ack | ((ack_lat != 0) && mem_req && (req_age == ack_lat - 1));

    // Transaction model: an access is outstanding, or in its one-cycle retirement slot.
    logic          m_active, m_retire, m_we, m_byte, m_rv, m_err;
    logic [DW-1:0] m_addr, m_wdata, m_rd;
    int            m_waited;
    logic          m_stall;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 0; m_retire <= 0; m_we <= 0; m_byte <= 0; m_rv <= 0; m_err <= 0;
            m_addr <= '0; m_wdata <= '0; m_rd <= '0; m_waited <= 0;
        end else begin
            m_rv <= 1'b0;
            if (m_retire) begin
                m_retire <= 1'b0;
            end else if (!m_active && MemReqM) begin
                m_active <= 1'b1; m_waited <= 1;
                m_addr <= ALUResultM; m_wdata <= WriteDataM;
                m_we <= MemWriteM; m_byte <= AddrModeM;
            end else if (m_active) begin
                if (mem_ack) begin
                    m_active <= 1'b0; m_retire <= 1'b1;
                    if (!m_we) begin m_rd <= mem_rdata; m_rv <= 1'b1; end
                end else if (m_waited == TO) begin
                    m_active <= 1'b0; m_retire <= 1'b1; m_err <= 1'b1;
                    if (!m_we) m_rd <= '0;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end
        end
    end
    assign m_stall = m_active || (!m_retire && MemReqM);

    always @(negedge clk) begin
        check("mem_req", {31'b0, mem_req}, {31'b0, m_active});
        check("mem_we", {31'b0, mem_we}, {31'b0, m_we});
        check("mem_byte", {31'b0, mem_byte}, {31'b0, m_byte});
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("StallM", {31'b0, StallM}, {31'b0, m_stall});
        check("BubbleW", {31'b0, BubbleW}, {31'b0, m_stall});
        check("ReadDataM", ReadDataM, m_rd);
        check("ReadValidM", {31'b0, ReadValidM}, {31'b0, m_rv});
        check("ErrorM", {31'b0, ErrorM}, {31'b0, m_err});
    end

    // Per-scenario activity counters, sampled mid-cycle.
    logic          cnt_clr = 1'b1;
    logic          prev_req;
    int            stall_n, req_n, rv_n, bursts, store_ok_n;
    logic [DW-1:0] rv_data;
    always @(negedge clk) begin
        if (cnt_clr) begin
            stall_n <= 0; req_n <= 0; rv_n <= 0; bursts <= 0; store_ok_n <= 0;
            rv_data <= '0; prev_req <= 1'b0;
        end else begin
            if (StallM) stall_n <= stall_n + 1;
            if (mem_req) req_n <= req_n + 1;
            if (ReadValidM) begin rv_n <= rv_n + 1; rv_data <= ReadDataM; end
            if (mem_req && !prev_req) bursts <= bursts + 1;
            if (mem_req && mem_we && mem_byte && mem_addr == 32'h20 && mem_wdata == 32'h1234)
                store_ok_n <= store_ok_n + 1;
            prev_req <= mem_req;
        end
    end

    task automatic clr_counts();
        MemReqM = 1'b0;
        cnt_clr = 1'b1;
        @(negedge clk);
        #1 cnt_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Hold an instruction in M until the pipeline lets it go; caller is at posedge+1.
    task automatic mem_op(input logic we, input logic bt, input logic [DW-1:0] a,
                          input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] rd,
                          input logic keep);
        logic leave;
        bit   left;
        MemWriteM = we; AddrModeM = bt; ALUResultM = a; WriteDataM = wd;
        ack_lat = lat; mem_rdata = rd; MemReqM = 1'b1;
        left = 0;
        for (int i = 0; i < 40; i++) begin
            #1 leave = !StallM;
            @(posedge clk);
            #1;
            if (leave) begin left = 1; break; end
        end
        if (!left) check("op_left_stage", 32'd0, 32'd1);
        if (!keep) MemReqM = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_ReadDataM", ReadDataM, 32'd0);
        check("reset_ErrorM", {31'b0, ErrorM}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Load, ack latency 1
        clr_counts();
        mem_op(1'b0, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0);
        check("ld1_stall", stall_n, 2);
        check("ld1_req", req_n, 1);
        check("ld1_rv", rv_n, 1);
        check("ld1_rvdata", rv_data, 32'hDEADBEEF);

        // Byte store, latency 4
        clr_counts();
        mem_op(1'b1, 1'b1, 32'h20, 32'h1234, 4, 32'hFFFF0000, 1'b0);
        check("st_stall", stall_n, 5);
        check("st_req", req_n, 4);
        check("st_stable", store_ok_n, 4);
        check("st_rv", rv_n, 0);
        check("st_rdata_kept", ReadDataM, 32'hDEADBEEF);

        // Back-to-back loads with MemReqM held high
        clr_counts();
        mem_op(1'b0, 1'b0, 32'h40, 32'h0, 2, 32'h11111111, 1'b1);
        mem_op(1'b0, 1'b0, 32'h44, 32'h0, 1, 32'h22222222, 1'b0);
        check("b2b_bursts", bursts, 2);
        check("b2b_req", req_n, 3);
        check("b2b_stall", stall_n, 5);
        check("b2b_rv", rv_n, 2);
        check("b2b_rdata", ReadDataM, 32'h22222222);

        // Ack in the last allowed cycle beats the timeout
        clr_counts();
        mem_op(1'b0, 1'b0, 32'h80, 32'h0, TO, 32'hCAFEF00D, 1'b0);
        check("late_req", req_n, TO);
        check("late_err", {31'b0, ErrorM}, 32'd0);
        check("late_rv", rv_n, 1);
        check("late_rdata", ReadDataM, 32'hCAFEF00D);

        // No ack at all: timeout
        clr_counts();
        mem_op(1'b0, 1'b0, 32'h84, 32'h0, 0, 32'h77777777, 1'b0);
        check("to_req", req_n, TO);
        check("to_stall", stall_n, TO + 1);
        check("to_err", {31'b0, ErrorM}, 32'd1);
        check("to_rdata", ReadDataM, 32'd0);
        check("to_rv", rv_n, 0);
        mem_op(1'b1, 1'b0, 32'h88, 32'h5, 1, 32'h0, 1'b0);
        check("to_err_sticky", {31'b0, ErrorM}, 32'd1);

        // Reset in the second BUSY cycle
        clr_counts();
        MemWriteM = 1'b0; ALUResultM = 32'h90; ack_lat = 0; MemReqM = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; MemReqM = 1'b0;
        #1;
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_idle", {31'b0, StallM}, 32'd0);
        check("rst_err", {31'b0, ErrorM}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clr_counts();
        mem_op(1'b0, 1'b0, 32'h200, 32'h0, 3, 32'h0BADC0DE, 1'b0);
        check("rst_fresh_req", req_n, 3);
        check("rst_fresh_rdata", rv_data, 32'h0BADC0DE);

        // Stray ack while idle
        clr_counts();
        force_ack = 1'b1; mem_rdata = 32'h55555555;
        repeat (3) @(posedge clk);
        #1;
        check("stray_rv", rv_n, 0);
        check("stray_req", req_n, 0);
        check("stray_rdata", ReadDataM, 32'h0BADC0DE);

        // Ack held high permanently: latency 1
        clr_counts();
        mem_op(1'b0, 1'b0, 32'h300, 32'h0, 0, 32'h600DF00D, 1'b0);
        check("held_stall", stall_n, 2);
        check("held_rdata", rv_data, 32'h600DF00D);
        force_ack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
